sequenciador_entradas: RTL and testbench



---
 rtl/sequenciador_entradas_pkg.sv | 19 +
 rtl/sequenciador_entradas_sincroniza_borda.sv | 35 +++
 rtl/sequenciador_entradas.sv | 158 +++++++++++++++
 tb/tb_sequenciador_entradas.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_entradas_pkg.sv
// Shared types and constants for the diabetes-risk detector input sequencer.
package sequenciador_entradas_pkg;

    typedef enum logic [1:0] {ENTRADA, CALCULA, RESULTADO, ERRO} estado_e;

    localparam int PREGNANCIES    = 0;
    localparam int GLUCOSE        = 1;
    localparam int BLOOD_PRESSURE = 2;
    localparam int SKIN_THICKNESS = 3;
    localparam int INSULIN        = 4;
    localparam int BMI            = 5;
    localparam int AGE            = 6;
    localparam int OUTCOME        = 7;

    localparam int NUM_CAMPOS_DEF = OUTCOME;
    localparam int DIGITOS_DEF    = 4;
    localparam int VAL_W_DEF      = 14;

endpackage

// File: rtl/sequenciador_entradas_sincroniza_borda.sv
// Two-flop synchroniser followed by a rising-edge detector, one lane per bit.
module sincroniza_borda #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sinc,
    output logic [W-1:0] borda
);
    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sinc  = s2_q;
    assign borda = s2_q & ~s3_q;

endmodule

// File: rtl/sequenciador_entradas.sv
// Keypad front-end: conditions raw buttons, sequences field entry and runs
// the start/done handshake with the classifier datapath.
module sequenciador_entradas
    import sequenciador_entradas_pkg::*;
#(
    parameter int NUM_CAMPOS = NUM_CAMPOS_DEF,
    parameter int DIGITOS    = DIGITOS_DEF,
    parameter int VAL_W      = VAL_W_DEF,
    parameter int TIMEOUT    = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  io,
    input  logic                        clear,
    input  logic                        prox,
    output logic                        clf_start,
    output logic [NUM_CAMPOS*VAL_W-1:0] clf_valores,
    input  logic                        clf_done,
    input  logic [3:0]                  clf_resultado,
    output logic [3:0]                  campo,
    output logic [4*DIGITOS-1:0]        bcd_display,
    output logic                        ocupado,
    output logic                        erro
);
    localparam int CW = $clog2(DIGITOS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(NUM_CAMPOS);

    logic [9:0] io_sinc, io_borda;
    logic       clear_sinc, clear_evt, prox_sinc, prox_evt;

    sincroniza_borda #(.W(10)) u_sinc_io (
        .clk(clk), .rst(rst), .din(io), .sinc(io_sinc), .borda(io_borda));
    sincroniza_borda #(.W(1)) u_sinc_clear (
        .clk(clk), .rst(rst), .din(clear), .sinc(clear_sinc), .borda(clear_evt));
    sincroniza_borda #(.W(1)) u_sinc_prox (
        .clk(clk), .rst(rst), .din(prox), .sinc(prox_sinc), .borda(prox_evt));

    logic unused_sinc;
    assign unused_sinc = clear_sinc ^ prox_sinc;

    estado_e                            estado_q, estado_d;
    logic [3:0]                         campo_q, campo_d;
    logic [CW-1:0]                      cont_q, cont_d;
    logic [4*DIGITOS-1:0]               bcd_q, bcd_d;
    logic [NUM_CAMPOS-1:0][VAL_W-1:0]   valores_q, valores_d;
    logic [TW-1:0]                      timer_q, timer_d;
    logic [3:0]                         resultado_q, resultado_d;
    logic                               clf_start_q, clf_start_d;

    logic       tecla_ok, limpa;
    logic [3:0] digito;
    logic [IW-1:0] idx;

    // A key only counts when exactly one synchronised key level is high.
    assign tecla_ok = $onehot(io_sinc) && (io_borda != '0);
    assign idx      = campo_q[IW-1:0];

    always_comb begin
        digito = 4'd0;
        for (int k = 0; k < 10; k++)
            if (io_sinc[k]) digito = 4'(k);
    end

    always_comb begin
        estado_d    = estado_q;
        campo_d     = campo_q;
        cont_d      = cont_q;
        bcd_d       = bcd_q;
        valores_d   = valores_q;
        timer_d     = timer_q;
        resultado_d = resultado_q;
        clf_start_d = 1'b0;
        limpa       = clear_evt;

        case (estado_q)
            ENTRADA: begin
                if (prox_evt) begin
                    if (idx == IW'(NUM_CAMPOS - 1)) begin
                        clf_start_d = 1'b1;
                        estado_d    = CALCULA;
                        campo_d     = 4'(NUM_CAMPOS);
                        timer_d     = '0;
                    end else begin
                        campo_d = campo_q + 4'd1;
                        bcd_d   = '0;
                        cont_d  = '0;
                    end
                end else if (tecla_ok && cont_q < CW'(DIGITOS)) begin
                    bcd_d          = {bcd_q[4*DIGITOS-5:0], digito};
                    valores_d[idx] = valores_q[idx] * VAL_W'(10) + VAL_W'(digito);
                    cont_d         = cont_q + CW'(1);
                end
            end
            CALCULA: begin
                // Done takes precedence over a coincident timeout.
                if (clf_done) begin
                    resultado_d = clf_resultado;
                    estado_d    = RESULTADO;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    estado_d = ERRO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESULTADO, ERRO: if (prox_evt) limpa = 1'b1;
            default: estado_d = ENTRADA;
        endcase

        if (limpa) begin
            estado_d    = ENTRADA;
            campo_d     = '0;
            cont_d      = '0;
            bcd_d       = '0;
            valores_d   = '0;
            timer_d     = '0;
            resultado_d = '0;
            clf_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= ENTRADA;
            campo_q     <= '0;
            cont_q      <= '0;
            bcd_q       <= '0;
            valores_q   <= '0;
            timer_q     <= '0;
            resultado_q <= '0;
            clf_start_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            campo_q     <= campo_d;
            cont_q      <= cont_d;
            bcd_q       <= bcd_d;
            valores_q   <= valores_d;
            timer_q     <= timer_d;
            resultado_q <= resultado_d;
            clf_start_q <= clf_start_d;
        end
    end

    always_comb begin
        case (estado_q)
            RESULTADO: bcd_display = (4*DIGITOS)'(resultado_q);
            ERRO:      bcd_display = '1;
            default:   bcd_display = bcd_q;
        endcase
    end

    assign clf_start   = clf_start_q;
    assign clf_valores = valores_q;
    assign campo       = campo_q;
    assign ocupado     = (estado_q == CALCULA);
    assign erro        = (estado_q == ERRO);

endmodule

// File: tb/tb_sequenciador_entradas.sv
// Bench for the input sequencer: vector table, randomized entry vs a
// decimal model, and hand-written handshake / timeout / reset sequences.
module tb_sequenciador_entradas;
    localparam int NC = 7;
    localparam int VW = 14;
    localparam int TO = 1023;

    logic             clk, rst, clear, prox, clf_done, clf_start, ocupado, erro;
    logic [9:0]       io;
    logic [NC*VW-1:0] clf_valores;
    logic [3:0]       clf_resultado, campo;
    logic [15:0]      bcd_display;

    sequenciador_entradas dut (
        .clk(clk), .rst(rst), .io(io), .clear(clear), .prox(prox),
        .clf_start(clf_start), .clf_valores(clf_valores), .clf_done(clf_done),
        .clf_resultado(clf_resultado), .campo(campo), .bcd_display(bcd_display),
        .ocupado(ocupado), .erro(erro));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, passed = 0;
    int vals[NC];
    int t_start;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_vec();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*VW +: VW] = VW'(vals[i]);
        return r;
    endfunction

    task automatic aplica(input logic [9:0] m, input bit p);
        @(negedge clk);
        io = m;
        prox = p;
        repeat (5) @(negedge clk);
        io = '0;
        prox = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic limpa();
        @(negedge clk);
        clear = 1'b1;
        repeat (5) @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Presses prox and counts how many cycles clf_start is seen high.
    task automatic prox_conta(output int n);
        n = 0;
        @(negedge clk);
        prox = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (clf_start) begin
                if (n == 0) t_start = cyc;
                n++;
            end
        end
        prox = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic vai_calcula();
        int n;
        repeat (NC - 1) aplica('0, 1'b1);
        prox_conta(n);
        chk("start_pulse", 128'(n), 128'd1);
    endtask

    typedef struct {
        logic [9:0]  io;
        bit          prox;
        logic [15:0] bcd;
        logic [3:0]  campo;
        int          fld;
        int          val;
    } vec_t;

    vec_t tab[11];

    initial begin
        int n, cnt, a, b, d, k;
        logic [9:0] m;

        tab[0]  = '{10'h002, 0, 16'h0001, 4'd0, 0, 1};
        tab[1]  = '{10'h010, 0, 16'h0014, 4'd0, 0, 14};
        tab[2]  = '{10'h100, 0, 16'h0148, 4'd0, 0, 148};
        tab[3]  = '{10'h000, 1, 16'h0000, 4'd1, 0, 148};
        tab[4]  = '{10'h200, 0, 16'h0009, 4'd1, 1, 9};
        tab[5]  = '{10'h200, 0, 16'h0099, 4'd1, 1, 99};
        tab[6]  = '{10'h200, 0, 16'h0999, 4'd1, 1, 999};
        tab[7]  = '{10'h200, 0, 16'h9999, 4'd1, 1, 9999};
        tab[8]  = '{10'h020, 0, 16'h9999, 4'd1, 1, 9999};
        tab[9]  = '{10'h028, 0, 16'h9999, 4'd1, 1, 9999};
        tab[10] = '{10'h004, 1, 16'h0000, 4'd2, 2, 0};

        rst = 1'b1; io = '0; clear = 1'b0; prox = 1'b0;
        clf_done = 1'b0; clf_resultado = '0;
        repeat (3) @(negedge clk);
        chk("rst_campo", 128'(campo), 128'd0);
        chk("rst_bcd", 128'(bcd_display), 128'd0);
        chk("rst_valores", 128'(clf_valores), 128'd0);
        chk("rst_start", 128'(clf_start), 128'd0);
        chk("rst_ocupado", 128'(ocupado), 128'd0);
        chk("rst_erro", 128'(erro), 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            aplica(tab[i].io, tab[i].prox);
            chk($sformatf("tab%0d_bcd", i), 128'(bcd_display), 128'(tab[i].bcd));
            chk($sformatf("tab%0d_campo", i), 128'(campo), 128'(tab[i].campo));
            chk($sformatf("tab%0d_val", i), 128'(clf_valores[tab[i].fld*VW +: VW]),
                128'(tab[i].val));
        end

        foreach (vals[i]) vals[i] = 0;
        vals[0] = 148;
        vals[1] = 9999;
        for (int f = 2; f < NC; f++) begin
            cnt = 0;
            n = $urandom_range(0, 6);
            repeat (n) begin
                if ($urandom_range(0, 4) == 0) begin
                    a = $urandom_range(0, 9);
                    b = (a + 1 + $urandom_range(0, 8)) % 10;
                    m = (10'(1) << a) | (10'(1) << b);
                end else begin
                    d = $urandom_range(0, 9);
                    m = 10'(1) << d;
                    if (cnt < 4) begin
                        vals[f] = vals[f] * 10 + d;
                        cnt++;
                    end
                end
                aplica(m, 1'b0);
                chk($sformatf("rnd_f%0d_bcd", f), 128'(bcd_display), 128'(to_bcd(vals[f])));
                chk($sformatf("rnd_f%0d_val", f), 128'(clf_valores[f*VW +: VW]), 128'(vals[f]));
            end
            if (f < NC - 1) begin
                aplica('0, 1'b1);
                chk($sformatf("rnd_f%0d_campo", f), 128'(campo), 128'(f + 1));
            end
        end
        chk("valores_all", 128'(clf_valores), exp_vec());

        prox_conta(n);
        chk("start_once", 128'(n), 128'd1);
        chk("calc_campo", 128'(campo), 128'd7);
        chk("calc_ocupado", 128'(ocupado), 128'd1);
        aplica(10'h008, 1'b1);
        repeat (10) @(negedge clk);
        chk("calc_valores_stable", 128'(clf_valores), exp_vec());
        chk("calc_still_busy", 128'(ocupado), 128'd1);
        clf_done = 1'b1; clf_resultado = 4'd1;
        @(negedge clk);
        clf_done = 1'b0; clf_resultado = 4'd0;
        @(negedge clk);
        chk("res_bcd", 128'(bcd_display), 128'h0001);
        chk("res_ocupado", 128'(ocupado), 128'd0);
        chk("res_campo", 128'(campo), 128'd7);
        aplica('0, 1'b1);
        chk("res_prox_campo", 128'(campo), 128'd0);
        chk("res_prox_valores", 128'(clf_valores), 128'd0);
        chk("res_prox_bcd", 128'(bcd_display), 128'd0);

        vai_calcula();
        k = 0;
        while (!erro && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("to_erro", 128'(erro), 128'd1);
        chk("to_cycles", 128'(cyc - t_start), 128'(TO));
        chk("to_bcd", 128'(bcd_display), 128'hFFFF);
        clf_done = 1'b1; clf_resultado = 4'd5;
        @(negedge clk);
        clf_done = 1'b0;
        chk("to_done_ignored", 128'(erro), 128'd1);
        limpa();
        chk("to_clr_erro", 128'(erro), 128'd0);
        chk("to_clr_campo", 128'(campo), 128'd0);
        chk("to_clr_bcd", 128'(bcd_display), 128'd0);

        vai_calcula();
        while (cyc < t_start + TO - 1) @(negedge clk);
        clf_done = 1'b1; clf_resultado = 4'd9;
        @(negedge clk);
        clf_done = 1'b0; clf_resultado = 4'd0;
        @(negedge clk);
        chk("tie_erro", 128'(erro), 128'd0);
        chk("tie_bcd", 128'(bcd_display), 128'h0009);
        aplica('0, 1'b1);

        vai_calcula();
        repeat (5) @(negedge clk);
        limpa();
        clf_done = 1'b1; clf_resultado = 4'd3;
        @(negedge clk);
        clf_done = 1'b0;
        @(negedge clk);
        chk("abort_ocupado", 128'(ocupado), 128'd0);
        chk("abort_bcd", 128'(bcd_display), 128'd0);
        chk("abort_campo", 128'(campo), 128'd0);

        repeat (3) aplica('0, 1'b1);
        aplica(10'h080, 1'b0);
        aplica(10'h004, 1'b0);
        chk("pre_rst_bcd", 128'(bcd_display), 128'h0072);
        chk("pre_rst_val", 128'(clf_valores), 128'(72) << (3*VW));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_campo", 128'(campo), 128'd0);
        chk("async_bcd", 128'(bcd_display), 128'd0);
        chk("async_valores", 128'(clf_valores), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
